imem_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 32 +++
 rtl/byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and frame constants for the boot-time instruction loader.
// Imported by the loader top and its byte packer.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port.
// The loader is the slave of the byte stream and the master of the write port.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words.
// Emits a one-cycle word_valid pulse the cycle after the last lane.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] acc;

  assign last_lane = (lane == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      lane       <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= '0;
        acc  <= '0;
      end else if (in_valid) begin
        unique case (lane)
          2'd0: acc[7:0]   <= in_data;
          2'd1: acc[15:8]  <= in_data;
          2'd2: acc[23:16] <= in_data;
          default: begin
            word       <= {in_data, acc};
            word_valid <= 1'b1;
          end
        endcase
        lane <= lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte frame -> instruction memory, XOR checksum,
// and core reset release once a frame loads cleanly.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_reset,
  output logic          done,
  output logic          error
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  state_t                state;
  state_t                nxt;
  logic                  rdy;
  logic [15:0]           len;
  logic [7:0]            xsum;
  logic [ADDR_WIDTH:0]   wcnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  xfer;
  logic                  clear;
  logic                  last_lane;
  logic                  word_valid;
  logic [31:0]           word;
  logic [15:0]           n;
  logic                  too_long;
  logic                  word_last;

  assign xfer     = bus.byte_valid && rdy;
  assign clear    = start && (state inside {IDLE, DONE, ERROR});
  assign n        = {bus.byte_data, len[7:0]};
  assign too_long = {16'd0, n} > DEPTH;
  // wcnt is one bit wider than the address so N = depth never wraps
  assign word_last =
    ({{(31 - ADDR_WIDTH){1'b0}}, wcnt} + 32'd1) == {16'd0, len};

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) nxt = LEN_LO;
      LEN_LO: if (xfer) nxt = LEN_HI;
      LEN_HI: if (xfer) begin
        if (n == 16'd0)    nxt = CHECK;
        else if (too_long) nxt = ERROR;
        else               nxt = DATA;
      end
      DATA: if (xfer && last_lane && word_last) nxt = CHECK;
      CHECK: if (xfer) nxt = (bus.byte_data == xsum) ? DONE : ERROR;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rdy        <= 1'b0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      len        <= '0;
      xsum       <= '0;
      wcnt       <= '0;
      addr       <= '0;
    end else begin
      state      <= nxt;
      rdy        <= nxt inside {LEN_LO, LEN_HI, DATA, CHECK};
      core_reset <= (nxt != DONE);
      done       <= (nxt == DONE);
      error      <= (nxt == ERROR);
      if (clear) begin
        len  <= '0;
        xsum <= '0;
        wcnt <= '0;
      end else if (xfer) begin
        unique case (state)
          LEN_LO: len[7:0]  <= bus.byte_data;
          LEN_HI: len[15:8] <= bus.byte_data;
          DATA: begin
            xsum <= xsum ^ bus.byte_data;
            if (last_lane) begin
              wcnt <= wcnt + 1'b1;
              addr <= wcnt[ADDR_WIDTH-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (xfer && (state == DATA)),
    .in_data   (bus.byte_data),
    .last_lane (last_lane),
    .word_valid(word_valid),
    .word      (word)
  );

  assign bus.byte_ready = rdy;
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum, length limits,
// byte gaps, mid-frame reset and full-depth load.
module tb_imem_loader;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic core_reset;
  logic done;
  logic error;

  int checks = 0;
  int passed = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  imem_loader_if #(.ADDR_WIDTH(8)) bus ();

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .core_reset(core_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_we) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    while (!bus.byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      $display("FAIL send_timeout got ready=%0b want 1", bus.byte_ready);
      bus.byte_valid = 1'b0;
    end else begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input bytes_t f, input bit gaps);
    foreach (f[i]) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hA5;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_byte(f[i]);
    end
  endtask

  function automatic bytes_t frame3();
    bytes_t f = '{8'h03, 8'h00,
                  8'h44, 8'h33, 8'h22, 8'h11,
                  8'h88, 8'h77, 8'h66, 8'h55,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE,
                  8'hAA};
    return f;
  endfunction

  task automatic check_frame3(input string tag);
    checks++;
    if (wa.size() !== 3)
      $display("FAIL %s_count got %0d want 3", tag, wa.size());
    else passed++;
    if (wa.size() == 3) begin
      checks++;
      if (wa[0] !== 8'd0 || wa[1] !== 8'd1 || wa[2] !== 8'd2)
        $display("FAIL %s_addr got %0d,%0d,%0d want 0,1,2",
                 tag, wa[0], wa[1], wa[2]);
      else passed++;
      checks++;
      if (wd[0] !== 32'h11223344 || wd[1] !== 32'h55667788 ||
          wd[2] !== 32'hDEADBEEF)
        $display("FAIL %s_data got %h,%h,%h want 11223344,55667788,deadbeef",
                 tag, wd[0], wd[1], wd[2]);
      else passed++;
    end
    checks++;
    if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0)
      $display("FAIL %s_status got d=%0b cr=%0b e=%0b want 1,0,0",
               tag, done, core_reset, error);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.byte_ready !== 1'b0)
      $display("FAIL rst_ready got %0b want 0", bus.byte_ready);
    else passed++;
    checks++;
    if (bus.imem_we !== 1'b0 || bus.imem_addr !== 8'd0)
      $display("FAIL rst_we_addr got %0b/%0d want 0/0",
               bus.imem_we, bus.imem_addr);
    else passed++;
    checks++;
    if (bus.imem_wdata !== 32'd0)
      $display("FAIL rst_wdata got %h want 0", bus.imem_wdata);
    else passed++;
    checks++;
    if (core_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL rst_status got cr=%0b d=%0b e=%0b want 1,0,0",
               core_reset, done, error);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_ok();
    bytes_t f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    wa.delete(); wd.delete();
    pulse_start();
    checks++;
    if (bus.byte_ready !== 1'b1)
      $display("FAIL ok_ready_after_start got %0b want 1", bus.byte_ready);
    else passed++;
    send_frame(f, 1'b0);
    checks++;
    if (wa.size() !== 2)
      $display("FAIL ok_count got %0d want 2", wa.size());
    else passed++;
    if (wa.size() == 2) begin
      checks++;
      if (wa[0] !== 8'd0 || wd[0] !== 32'h00000013)
        $display("FAIL ok_word0 got %0d:%h want 0:00000013", wa[0], wd[0]);
      else passed++;
      checks++;
      if (wa[1] !== 8'd1 || wd[1] !== 32'h00100093)
        $display("FAIL ok_word1 got %0d:%h want 1:00100093", wa[1], wd[1]);
      else passed++;
    end
    checks++;
    if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0)
      $display("FAIL ok_status got d=%0b cr=%0b e=%0b want 1,0,0",
               done, core_reset, error);
    else passed++;
    checks++;
    if (bus.byte_ready !== 1'b0)
      $display("FAIL ok_ready_done got %0b want 0", bus.byte_ready);
    else passed++;
  endtask

  task automatic test_bad_checksum();
    bytes_t f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    wa.delete(); wd.delete();
    pulse_start();
    checks++;
    if (core_reset !== 1'b1 || done !== 1'b0)
      $display("FAIL bad_restart got cr=%0b d=%0b want 1,0",
               core_reset, done);
    else passed++;
    send_frame(f, 1'b0);
    checks++;
    if (wa.size() !== 2 || (wa.size() == 2 && wd[1] !== 32'h00100093))
      $display("FAIL bad_writes got %0d writes want 2", wa.size());
    else passed++;
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1)
      $display("FAIL bad_status got e=%0b d=%0b cr=%0b want 1,0,1",
               error, done, core_reset);
    else passed++;
  endtask

  task automatic test_zero_len();
    bytes_t f = '{8'h00, 8'h00, 8'h00};
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(f, 1'b0);
    checks++;
    if (wa.size() !== 0)
      $display("FAIL zero_writes got %0d want 0", wa.size());
    else passed++;
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || core_reset !== 1'b0)
      $display("FAIL zero_status got d=%0b e=%0b cr=%0b want 1,0,0",
               done, error, core_reset);
    else passed++;
  endtask

  task automatic test_too_long();
    bytes_t f = '{8'h01, 8'h01};
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(f, 1'b0);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1)
      $display("FAIL long_status got e=%0b d=%0b cr=%0b want 1,0,1",
               error, done, core_reset);
    else passed++;
    checks++;
    if (bus.byte_ready !== 1'b0)
      $display("FAIL long_ready got %0b want 0", bus.byte_ready);
    else passed++;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h13;
    repeat (6) @(negedge clk);
    bus.byte_valid = 1'b0;
    checks++;
    if (wa.size() !== 0 || error !== 1'b1)
      $display("FAIL long_writes got %0d writes e=%0b want 0,1",
               wa.size(), error);
    else passed++;
  endtask

  task automatic test_gaps();
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(frame3(), 1'b1);
    check_frame3("gaps");
  endtask

  task automatic test_reset_mid();
    bytes_t f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00};
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(f, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (core_reset !== 1'b1 || bus.imem_we !== 1'b0 ||
        bus.byte_ready !== 1'b0 || bus.imem_addr !== 8'd0)
      $display("FAIL mid_reset got cr=%0b we=%0b rdy=%0b a=%0d want 1,0,0,0",
               core_reset, bus.imem_we, bus.byte_ready, bus.imem_addr);
    else passed++;
    reset = 1'b0;
    wa.delete(); wd.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() !== 0 || bus.byte_ready !== 1'b0)
      $display("FAIL mid_idle got %0d writes rdy=%0b want 0,0",
               wa.size(), bus.byte_ready);
    else passed++;
    pulse_start();
    send_frame(frame3(), 1'b0);
    check_frame3("mid_reload");
  endtask

  task automatic test_full_depth();
    int bad = 0;
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
    end
    send_byte(8'h00);
    checks++;
    if (wa.size() !== 256)
      $display("FAIL full_count got %0d want 256", wa.size());
    else passed++;
    foreach (wa[i]) begin
      if (wa[i] !== 8'(i) || wd[i] !== 32'(i)) bad++;
    end
    checks++;
    if (bad !== 0)
      $display("FAIL full_words got %0d bad want 0", bad);
    else passed++;
    checks++;
    if (done !== 1'b1 || error !== 1'b0)
      $display("FAIL full_status got d=%0b e=%0b want 1,0", done, error);
    else passed++;
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_load_ok();
    test_bad_checksum();
    test_zero_len();
    test_too_long();
    test_gaps();
    test_reset_mid();
    test_full_depth();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
